// File: rtl/ram16x8_pkg.sv
// Shared sizes and types for the 16x8 scratch-pad RAM.
package ram16x8_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : ram16x8_pkg

// File: rtl/ram16x8_ctrl.sv
// Decodes chip select and the two enables into one-hot-ish access strobes.
// wr_fire_o : a write happens this edge
// rd_fire_o : a plain read (no write) updates the output register this edge
// wt_fire_o : write and read requested together; the top decides what the
//             output register does in that case
module ram16x8_ctrl (
  input  logic cs_i,
  input  logic w_en_i,
  input  logic op_en_i,
  output logic wr_fire_o,
  output logic rd_fire_o,
  output logic wt_fire_o
);

  // Purely combinational qualification of the enables by chip select.
  always_comb begin
    wr_fire_o = cs_i & w_en_i;
    rd_fire_o = cs_i & op_en_i & ~w_en_i;
    wt_fire_o = cs_i & w_en_i & op_en_i;
  end

endmodule : ram16x8_ctrl

// File: rtl/ram16x8.sv
// 16 x 8 synchronous single-port RAM with chip select, write enable,
// output enable and a registered read port.
// reset_n is ACTIVE-HIGH and synchronous; the name is historical.
// Optional build macro RAM16X8_WRITE_THROUGH_EN: when a write and a read are
// requested together, the written data is also loaded into data_out.
// Without it, the write wins and data_out keeps its previous value.
module ram16x8
  import ram16x8_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic              w_en,
  input  logic              op_en,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  data_t mem_q [DEPTH];
  data_t data_out_q;
  data_t data_out_d;

  logic wr_fire;
  logic rd_fire;
  logic wt_fire;

  ram16x8_ctrl u_ctrl (
    .cs_i      (cs),
    .w_en_i    (w_en),
    .op_en_i   (op_en),
    .wr_fire_o (wr_fire),
    .rd_fire_o (rd_fire),
    .wt_fire_o (wt_fire)
  );

  // Storage: cleared by reset so reads never return X, otherwise written on wr_fire.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_fire) begin
      mem_q[addr_in] <= data_in;
    end
  end

  // Next read-data value: hold by default, load on a read, special-case write+read.
  always_comb begin
    data_out_d = data_out_q;
    if (rd_fire) begin
      data_out_d = mem_q[addr_in];
    end else if (wt_fire) begin
`ifdef RAM16X8_WRITE_THROUGH_EN
      data_out_d = data_in;
`else
      data_out_d = data_out_q;
`endif
    end
  end

  // Registered read data; only reset ever forces it to zero.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule : ram16x8

// File: tb/tb_ram16x8.sv
// Scoreboard bench for ram16x8: the driver pushes the expected data_out for
// selected cycles, a separate monitor pops and compares on the falling edge.
// Honours RAM16X8_WRITE_THROUGH_EN for the simultaneous write/read case.
module tb_ram16x8;

  logic       clk;
  logic       reset_n;
  logic       cs;
  logic       w_en;
  logic       op_en;
  logic [3:0] addr_in;
  logic [7:0] data_in;
  logic [7:0] data_out;

  typedef struct {
    logic [7:0] expData;
    string      name;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  int compared   = 0;
  int mismatched = 0;

  logic [7:0] sweepVals [16];

  ram16x8 dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cs       (cs),
    .w_en     (w_en),
    .op_en    (op_en),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .data_out (data_out)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one scoreboard entry against the current DUT output.
  task automatic checkOutput(input sbEntry_t e);
    compared++;
    if (data_out !== e.expData) begin
      mismatched++;
      $display("[TB] FAIL %s: data_out=%02h expected=%02h", e.name, data_out, e.expData);
    end
  endtask

  // Monitor: one posedge after an entry is pushed, compare it mid-cycle.
  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      checkOutput(sbQ.pop_front());
    end
  end

  // Drive one cycle of inputs, let the edge happen, optionally queue an expectation.
  task automatic applyStimulus(input logic rst, input logic c, input logic w,
                               input logic o, input logic [3:0] a,
                               input logic [7:0] d, input bit chk,
                               input logic [7:0] expData, input string name);
    sbEntry_t e;
    @(negedge clk);
    reset_n = rst;
    cs      = c;
    w_en    = w;
    op_en   = o;
    addr_in = a;
    data_in = d;
    @(posedge clk);
    if (chk) begin
      e.expData = expData;
      e.name    = name;
      sbQ.push_back(e);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, queue=%0d expected=0", sbQ.size());
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    sweepVals = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                  8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    reset_n = 1'b1;
    cs      = 1'b0;
    w_en    = 1'b0;
    op_en   = 1'b0;
    addr_in = '0;
    data_in = '0;

    // Reset held two cycles while a write is requested: it must be ignored.
    applyStimulus(1, 1, 1, 0, 4'h0, 8'hFF, 1, 8'h00, "reset_cyc0");
    applyStimulus(1, 1, 1, 0, 4'h0, 8'hFF, 1, 8'h00, "reset_cyc1");

    // Every word reads zero after reset.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 0, 1, 4'(i), 8'h00, 1, 8'h00, $sformatf("post_reset_rd%0d", i));
    end

    // Write does not disturb data_out; read returns it one edge later.
    applyStimulus(0, 1, 1, 0, 4'h3, 8'hA5, 1, 8'h00, "write3_out_hold");
    applyStimulus(0, 1, 0, 1, 4'h3, 8'h00, 1, 8'hA5, "read3");

    // Chip select low blocks the write and blocks read updates.
    applyStimulus(0, 0, 1, 0, 4'h3, 8'h5A, 1, 8'hA5, "cs0_write");
    applyStimulus(0, 1, 0, 1, 4'h3, 8'h00, 1, 8'hA5, "read3_after_cs0");
    applyStimulus(0, 0, 0, 1, 4'h0, 8'h00, 1, 8'hA5, "cs0_read_hold");
    applyStimulus(0, 1, 0, 0, 4'h0, 8'h00, 1, 8'hA5, "cs1_idle_hold");

    // Full sweep write, then reverse-order readback.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 1, 0, 4'(i), sweepVals[i], 0, 8'h00, "");
    end
    for (int i = 15; i >= 0; i--) begin
      applyStimulus(0, 1, 0, 1, 4'(i), 8'h00, 1, sweepVals[i], $sformatf("sweep_rd%0d", i));
    end

    // Restore A5 at addr 3 and make it the current output.
    applyStimulus(0, 1, 1, 0, 4'h3, 8'hA5, 0, 8'h00, "");
    applyStimulus(0, 1, 0, 1, 4'h3, 8'h00, 1, 8'hA5, "reread3");

    // Simultaneous write and read to addr 7.
`ifdef RAM16X8_WRITE_THROUGH_EN
    applyStimulus(0, 1, 1, 1, 4'h7, 8'h3C, 1, 8'h3C, "simul_wr_rd");
`else
    applyStimulus(0, 1, 1, 1, 4'h7, 8'h3C, 1, 8'hA5, "simul_wr_rd");
`endif
    applyStimulus(0, 1, 0, 1, 4'h7, 8'h00, 1, 8'h3C, "read7_after_simul");

    // Read addr 3 then idle ten cycles; output must hold.
    applyStimulus(0, 1, 0, 1, 4'h3, 8'h00, 1, 8'hA5, "read3_before_hold");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 0, 0, 4'(i), 8'h99, 1, 8'hA5, $sformatf("hold_cyc%0d", i));
    end

    // One-edge reset with a pending write to addr 3: write discarded.
    applyStimulus(1, 1, 1, 0, 4'h3, 8'h77, 1, 8'h00, "mid_reset");
    applyStimulus(0, 1, 0, 1, 4'h3, 8'h00, 1, 8'h00, "read3_after_reset");
    applyStimulus(0, 1, 0, 1, 4'h7, 8'h00, 1, 8'h00, "read7_after_reset");

    // Let the monitor drain the scoreboard.
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 4'h0, 8'h00, 0, 8'h00, "");
    @(negedge clk);
    #1;
    if (sbQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: pending=%0d expected=0", sbQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_ram16x8
